multicycle_control: RTL and testbench

Moore-style control FSM for the multicycle RISC-V datapath. It consumes the 7-bit opcode from the datapath and drives every datapath control input, sequencing fetch, decode, execute, memory and write-back over 3-5 cycles per instruction. Supported subset: ld, sd, R-type ALU ops and beq. It also flags unsupported opcodes and pulses once per retired instruction for performance counting.

---
 rtl/multicycle_control_pkg.sv | 107 ++++++++++
 rtl/multicycle_control_if.sv | 38 +++
 rtl/multicycle_control.sv | 77 +++++++
 tb/tb_multicycle_control.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle RISC-V control path:
// opcodes, FSM states, ALU selects and the control bundle.
package riscv_mc_pkg;

    localparam logic [6:0] OP_LD    = 7'b000_0011;
    localparam logic [6:0] OP_SD    = 7'b010_0011;
    localparam logic [6:0] OP_RTYPE = 7'b011_0011;
    localparam logic [6:0] OP_BEQ   = 7'b110_0011;

    typedef enum logic [3:0] {
        S_RESET  = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_RWB    = 4'd8,
        S_BRANCH = 4'd9
    } state_e;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10
    } alu_op_e;

    typedef enum logic [1:0] {
        SRCB_RS2  = 2'b00,
        SRCB_FOUR = 2'b01,
        SRCB_IMM  = 2'b10,
        SRCB_OFF  = 2'b11
    } src_b_e;

    typedef struct packed {
        logic [1:0] alu_op;
        logic [1:0] alu_src_b;
        logic       alu_src_a;
        logic       mem_to_reg;
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        logic       reg_write;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic       pc_source;
        logic       retire;
    } ctrl_t;

    function automatic logic op_legal(logic [6:0] op);
        return (op == OP_LD) || (op == OP_SD) ||
               (op == OP_RTYPE) || (op == OP_BEQ);
    endfunction

    // Moore decode; unused encodings fall through to all-zero
    function automatic ctrl_t ctrl_of(state_e s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.ir_write  = 1'b1;
                c.alu_src_b = SRCB_FOUR;
                c.pc_write  = 1'b1;
            end
            S_DECODE: c.alu_src_b = SRCB_OFF;
            S_MEMADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                c.mem_read = 1'b1;
                c.i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
                c.retire     = 1'b1;
            end
            S_MEMWR: begin
                c.mem_write = 1'b1;
                c.i_or_d    = 1'b1;
                c.retire    = 1'b1;
            end
            S_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = ALU_FUNCT;
            end
            S_RWB: begin
                c.reg_write = 1'b1;
                c.retire    = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = ALU_SUB;
                c.pc_write_cond = 1'b1;
                c.pc_source     = 1'b1;
                c.retire        = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control bus between the multicycle FSM (master) and the
// datapath (slave).
interface multicycle_control_if;

    logic [6:0] opcode;
    logic [1:0] ALUOp;
    logic [1:0] ALUSrcB;
    logic       ALUSrcA;
    logic       MemtoReg;
    logic       MemRead;
    logic       MemWrite;
    logic       IorD;
    logic       RegWrite;
    logic       IRWrite;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       PCSource;
    logic [3:0] state_dbg;
    logic       illegal_op;
    logic       retire;

    modport master (
        input  opcode,
        output ALUOp, ALUSrcB, ALUSrcA, MemtoReg,
        output MemRead, MemWrite, IorD, RegWrite,
        output IRWrite, PCWrite, PCWriteCond, PCSource,
        output state_dbg, illegal_op, retire
    );

    modport slave (
        output opcode,
        input  ALUOp, ALUSrcB, ALUSrcA, MemtoReg,
        input  MemRead, MemWrite, IorD, RegWrite,
        input  IRWrite, PCWrite, PCWriteCond, PCSource,
        input  state_dbg, illegal_op, retire
    );

endinterface

// File: rtl/multicycle_control.sv
// Moore control FSM sequencing fetch/decode/execute/mem/wb
// for ld, sd, R-type and beq on the multicycle datapath.
module multicycle_control
    import riscv_mc_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    multicycle_control_if.master bus
);

    state_e state_q, state_d;
    ctrl_t  ctrl_q, ctrl_d;

    logic is_mem;
    logic is_rtype;
    logic is_beq;

    always_comb begin
        is_mem   = (bus.opcode == OP_LD) ||
                   (bus.opcode == OP_SD);
        is_rtype = (bus.opcode == OP_RTYPE);
        is_beq   = (bus.opcode == OP_BEQ);
    end

    always_comb begin
        state_d = S_FETCH;
        unique case (state_q)
            S_RESET:  state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                unique case (1'b1)
                    is_mem:   state_d = S_MEMADR;
                    is_rtype: state_d = S_EXEC;
                    is_beq:   state_d = S_BRANCH;
                    default:  state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = (bus.opcode == OP_LD) ?
                                S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = S_MEMWB;
            S_EXEC:   state_d = S_RWB;
            default:  state_d = S_FETCH;
        endcase
        // Outputs are registered from the next state so they
        // always equal a pure decode of the state register.
        ctrl_d = ctrl_of(state_d);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_RESET;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign bus.ALUOp       = ctrl_q.alu_op;
    assign bus.ALUSrcB     = ctrl_q.alu_src_b;
    assign bus.ALUSrcA     = ctrl_q.alu_src_a;
    assign bus.MemtoReg    = ctrl_q.mem_to_reg;
    assign bus.MemRead     = ctrl_q.mem_read;
    assign bus.MemWrite    = ctrl_q.mem_write;
    assign bus.IorD        = ctrl_q.i_or_d;
    assign bus.RegWrite    = ctrl_q.reg_write;
    assign bus.IRWrite     = ctrl_q.ir_write;
    assign bus.PCWrite     = ctrl_q.pc_write;
    assign bus.PCWriteCond = ctrl_q.pc_write_cond;
    assign bus.PCSource    = ctrl_q.pc_source;
    assign bus.retire      = ctrl_q.retire;
    assign bus.state_dbg   = state_q;

    assign bus.illegal_op  = (state_q == S_DECODE) &&
                             !op_legal(bus.opcode);

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle state and
// control expectations queued at drive time, checked each cycle.
module tb_multicycle_control;

    typedef struct packed {
        logic [1:0] alu_op;
        logic [1:0] src_b;
        logic       src_a;
        logic       mtr;
        logic       mrd;
        logic       mwr;
        logic       iord;
        logic       rw;
        logic       irw;
        logic       pcw;
        logic       pcwc;
        logic       pcs;
        logic       ret;
        logic       ill;
    } outs_t;

    typedef struct {
        int    st;
        outs_t o;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    always #5 clock = ~clock;

    multicycle_control_if bus();

    multicycle_control dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    function automatic outs_t observe();
        outs_t o;
        o.alu_op = bus.ALUOp;
        o.src_b  = bus.ALUSrcB;
        o.src_a  = bus.ALUSrcA;
        o.mtr    = bus.MemtoReg;
        o.mrd    = bus.MemRead;
        o.mwr    = bus.MemWrite;
        o.iord   = bus.IorD;
        o.rw     = bus.RegWrite;
        o.irw    = bus.IRWrite;
        o.pcw    = bus.PCWrite;
        o.pcwc   = bus.PCWriteCond;
        o.pcs    = bus.PCSource;
        o.ret    = bus.retire;
        o.ill    = bus.illegal_op;
        return o;
    endfunction

    function automatic outs_t model(int st, logic [6:0] op);
        outs_t o;
        o = '0;
        case (st)
            1: begin
                o.mrd = 1; o.irw = 1; o.pcw = 1;
                o.src_b = 2'b01;
            end
            2: begin
                o.src_b = 2'b11;
                o.ill = !(op == 7'b0000011 || op == 7'b0100011 ||
                          op == 7'b0110011 || op == 7'b1100011);
            end
            3: begin o.src_a = 1; o.src_b = 2'b10; end
            4: begin o.mrd = 1; o.iord = 1; end
            5: begin o.rw = 1; o.mtr = 1; o.ret = 1; end
            6: begin o.mwr = 1; o.iord = 1; o.ret = 1; end
            7: begin o.src_a = 1; o.alu_op = 2'b10; end
            8: begin o.rw = 1; o.ret = 1; end
            9: begin
                o.src_a = 1; o.alu_op = 2'b01;
                o.pcwc = 1; o.pcs = 1; o.ret = 1;
            end
            default: o = '0;
        endcase
        return o;
    endfunction

    function automatic int seq_len(logic [6:0] op);
        case (op)
            7'b0000011: return 5;
            7'b0100011: return 4;
            7'b0110011: return 4;
            7'b1100011: return 3;
            default:    return 2;
        endcase
    endfunction

    function automatic int seq_state(logic [6:0] op, int k);
        int ld[5] = '{1, 2, 3, 4, 5};
        int sd[4] = '{1, 2, 3, 6};
        int rt[4] = '{1, 2, 7, 8};
        int bq[3] = '{1, 2, 9};
        case (op)
            7'b0000011: return ld[k];
            7'b0100011: return sd[k];
            7'b0110011: return rt[k];
            7'b1100011: return bq[k];
            default:    return (k == 0) ? 1 : 2;
        endcase
    endfunction

    task automatic test_reset();
        exp_t e;
        for (int c = 0; c < 3; c++) begin
            @(posedge clock); #1;
            sb.push_back('{0, outs_t'(0)});
            e = sb.pop_front();
            total++;
            if (bus.state_dbg !== 4'(e.st)) begin
                bad++;
                $display("FAIL rst_hold_st got=%0d exp=%0d",
                         bus.state_dbg, e.st);
            end
            total++;
            if (observe() !== e.o) begin
                bad++;
                $display("FAIL rst_hold_out got=%b exp=%b",
                         observe(), e.o);
            end
        end
        @(negedge clock);
        reset = 1'b0;
        #1;
        total++;
        if (bus.state_dbg !== 4'd0) begin
            bad++;
            $display("FAIL rst_release_st got=%0d exp=0",
                     bus.state_dbg);
        end
        @(posedge clock); #1;
        sb.push_back('{1, model(1, bus.opcode)});
        e = sb.pop_front();
        total++;
        if (bus.state_dbg !== 4'(e.st) || observe() !== e.o) begin
            bad++;
            $display("FAIL rst_fetch got=%0d/%b exp=%0d/%b",
                     bus.state_dbg, observe(), e.st, e.o);
        end
    endtask

    task automatic test_sequence(string name,
                                 logic [6:0] ops [8], int n);
        exp_t e;
        int   len;
        for (int i = 0; i < n; i++) begin
            bus.opcode = ops[i];
            len = seq_len(ops[i]);
            for (int k = 0; k < len; k++) begin
                int s;
                s = seq_state(ops[i], k);
                sb.push_back('{s, model(s, ops[i])});
            end
            for (int k = 0; k < len; k++) begin
                if (k > 0) begin
                    @(posedge clock); #1;
                end
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL %s sb_empty got=0 exp=1", name);
                    continue;
                end
                e = sb.pop_front();
                if (bus.state_dbg !== 4'(e.st)) begin
                    bad++;
                    $display("FAIL %s st op=%b got=%0d exp=%0d",
                             name, ops[i], bus.state_dbg, e.st);
                end
                total++;
                if (observe() !== e.o) begin
                    bad++;
                    $display("FAIL %s out op=%b st=%0d got=%b exp=%b",
                             name, ops[i], e.st, observe(), e.o);
                end
            end
            @(posedge clock); #1;
        end
        sb.push_back('{1, model(1, bus.opcode)});
        e = sb.pop_front();
        total++;
        if (bus.state_dbg !== 4'(e.st) || observe() !== e.o) begin
            bad++;
            $display("FAIL %s end got=%0d/%b exp=%0d/%b",
                     name, bus.state_dbg, observe(), e.st, e.o);
        end
    endtask

    task automatic test_reset_mid();
        bus.opcode = 7'b0100011;
        repeat (3) begin
            @(posedge clock); #1;
        end
        total++;
        if (bus.state_dbg !== 4'd6 || bus.MemWrite !== 1'b1) begin
            bad++;
            $display("FAIL mid_pre got=%0d/%b exp=6/1",
                     bus.state_dbg, bus.MemWrite);
        end
        #2 reset = 1'b1;
        #1;
        total++;
        if (bus.MemWrite !== 1'b0 || bus.state_dbg !== 4'd0) begin
            bad++;
            $display("FAIL mid_async got=%0d/%b exp=0/0",
                     bus.state_dbg, bus.MemWrite);
        end
        total++;
        if (observe() !== outs_t'(0)) begin
            bad++;
            $display("FAIL mid_outs got=%b exp=0", observe());
        end
        @(negedge clock);
        reset = 1'b0;
        #1;
        total++;
        if (bus.state_dbg !== 4'd0) begin
            bad++;
            $display("FAIL mid_hold got=%0d exp=0", bus.state_dbg);
        end
        @(posedge clock); #1;
        total++;
        if (bus.state_dbg !== 4'd1 ||
            observe() !== model(1, bus.opcode)) begin
            bad++;
            $display("FAIL mid_fetch got=%0d/%b exp=1/%b",
                     bus.state_dbg, observe(), model(1, bus.opcode));
        end
    endtask

    initial begin
        logic [6:0] pool [5];
        logic [6:0] rnd  [8];
        pool = '{7'b0000011, 7'b0100011, 7'b0110011,
                 7'b1100011, 7'b1111111};
        bus.opcode = 7'd0;
        test_reset();
        test_sequence("rtype", '{7'b0110011, 0, 0, 0, 0, 0, 0, 0}, 1);
        test_sequence("ld", '{7'b0000011, 0, 0, 0, 0, 0, 0, 0}, 1);
        test_sequence("sd_beq",
                      '{7'b0100011, 7'b1100011, 0, 0, 0, 0, 0, 0}, 2);
        test_sequence("illegal", '{7'b1111111, 0, 0, 0, 0, 0, 0, 0}, 1);
        test_sequence("ill_zero", '{7'b0000000, 7'b0010011,
                                    0, 0, 0, 0, 0, 0}, 2);
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 8; i++)
                rnd[i] = pool[$urandom_range(0, 4)];
            test_sequence("back_to_back", rnd, 8);
        end
        test_reset_mid();
        test_sequence("post_reset", '{7'b1100011, 7'b0110011,
                                      0, 0, 0, 0, 0, 0}, 2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
